// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter.
// Producers push bytes at full clock rate. One byte at a time is handed to
// the transmitter with a single-cycle tx_start pulse. The next byte is held
// back until the transmitter returns tx_done.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,  // entries, power of two, >= 2
    parameter int ADDR_W = 4    // log2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              wr_overflow,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_done,
    output logic              busy
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    // S_IDLE: free to pop the next byte; S_WAIT: a frame is on the wire
    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t              state_q,    state_d;
    logic [ADDR_W-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [ADDR_W:0]     count_q,    count_d;
    logic                overflow_q, overflow_d;
    logic                tx_start_q, tx_start_d;
    logic [7:0]          tx_data_q,  tx_data_d;

    logic [7:0]          mem [DEPTH];

    logic                wr_accept;
    logic                pop;

    // Status flags come straight from the stored-byte count
    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);

    // Push and pop qualifiers, both judged on the pre-edge count so a pop in
    // the same cycle never makes room for a write to a full FIFO
    always_comb begin
        wr_accept = wr_en && !full;
        pop       = (state_q == S_IDLE) && !empty;
    end

    // Pointer, count and overflow next-state
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path
        // leaves it unassigned, which would infer a latch.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = wr_en && full;

        // Pointers wrap naturally because DEPTH is a power of two
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        // Simultaneous push and pop leave the count unchanged
        case ({wr_accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Handoff FSM: pop into tx_data with a one-cycle tx_start, then wait for tx_done
    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    tx_data_d  = mem[rd_ptr_q];
                    tx_start_d = 1'b1;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                // No timeout: the transmitter is trusted to finish every frame
                if (tx_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every flop samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Byte storage
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; an entry is only ever read
        // after it has been written, because pops require a non-zero count.
        if (wr_accept) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign count       = count_q;
    assign wr_overflow = overflow_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign busy        = (state_q != S_IDLE) || !empty;

endmodule
